// File: rtl/switch_debounce.sv
// ---------------------------------------------------------------------------
// switch_debounce
//
// Synchronises and debounces the eight raw front-panel switch lines. The pins
// are active-low (pulled up when open) and that polarity is kept on the
// debounced output; inversion is left to the downstream bus-read stage.
//
// Each bit runs through a 2-flop synchroniser and then an independent
// stability filter: the synchronised bit must disagree with the debounced
// value for STABLE_COUNT consecutive cycles before the debounced value
// follows it. Any single cycle of agreement restarts the count.
//
// Parameters
//   STABLE_COUNT : consecutive disagreeing cycles needed to update (>= 2)
//   CNT_WIDTH    : per-bit counter width, 2**CNT_WIDTH > STABLE_COUNT-1
//
// Ports
//   clk                     in   system clock, rising edge
//   reset_n                 in   synchronous active-low reset
//   switch_debounce_raw     in   [8:1] asynchronous raw pins, active-low
//   switch_debounce_out     out  [8:1] debounced vector, same polarity as raw
//   switch_debounce_changed out  [8:1] one-cycle pulse per bit that updated
//   switch_debounce_event   out  sticky "something changed" flag
//   switch_debounce_ack     in   synchronous clear for the event flag
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output.
// ---------------------------------------------------------------------------
module switch_debounce #(
  parameter int STABLE_COUNT = 50000,
  parameter int CNT_WIDTH    = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [8:1] switch_debounce_raw,
  output logic [8:1] switch_debounce_out,
  output logic [8:1] switch_debounce_changed,
  output logic       switch_debounce_event,
  input  logic       switch_debounce_ack
);

  // Terminal count: the edge on which the counter already holds this value
  // (and the bit still disagrees) is the edge on which the output updates.
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  // -------------------------------------------------------------------------
  // Two-stage synchroniser. Reset loads the "all open" level so the filter
  // sees agreement with the reset value of the output while reset is held.
  // -------------------------------------------------------------------------
  logic [8:1] sync1_reg;
  logic [8:1] sync2_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_reg <= 8'hFF;
      sync2_reg <= 8'hFF;
    end else begin
      sync1_reg <= switch_debounce_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Per-bit stability filters. Each channel is fully self-contained; the
  // update strobes are gathered into upd_next for the shared event flag.
  // -------------------------------------------------------------------------
  logic [8:1] upd_next;
  logic [8:1] out_reg;
  logic [8:1] changed_reg;

  generate
    for (genvar gi = 1; gi <= 8; gi++) begin : g_chan
      logic [CNT_WIDTH-1:0] cnt_reg;
      logic [CNT_WIDTH-1:0] cnt_next;
      logic                 bit_out_reg;
      logic                 bit_out_next;
      logic                 bit_upd_next;
      logic                 bit_changed_reg;

      always_comb begin
        cnt_next     = cnt_reg;
        bit_out_next = bit_out_reg;
        bit_upd_next = 1'b0;
        if (sync2_reg[gi] == bit_out_reg) begin
          // Agreement (including a bounce back) discards the partial count.
          cnt_next = CNT_ZERO;
        end else if (cnt_reg >= CNT_MAX) begin
          // Disagreed for STABLE_COUNT consecutive cycles: accept the level.
          // The >= keeps the counter from ever running past its limit.
          bit_out_next = sync2_reg[gi];
          bit_upd_next = 1'b1;
          cnt_next     = CNT_ZERO;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          cnt_reg         <= CNT_ZERO;
          bit_out_reg     <= 1'b1;
          bit_changed_reg <= 1'b0;
        end else begin
          cnt_reg         <= cnt_next;
          bit_out_reg     <= bit_out_next;
          // Registered alongside the output so the pulse is high exactly in
          // the cycle where the new level first appears.
          bit_changed_reg <= bit_upd_next;
        end
      end

      assign upd_next[gi]    = bit_upd_next;
      assign out_reg[gi]     = bit_out_reg;
      assign changed_reg[gi] = bit_changed_reg;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Sticky event flag. A new update takes precedence over an ack on the
  // same edge so that no event can be silently lost.
  // -------------------------------------------------------------------------
  logic event_reg;
  logic event_next;

  always_comb begin
    event_next = event_reg;
    if (|upd_next) begin
      event_next = 1'b1;
    end else if (switch_debounce_ack) begin
      event_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      event_reg <= 1'b0;
    end else begin
      event_reg <= event_next;
    end
  end

  assign switch_debounce_out     = out_reg;
  assign switch_debounce_changed = changed_reg;
  assign switch_debounce_event   = event_reg;

endmodule

// File: tb/tb_switch_debounce.sv
// ---------------------------------------------------------------------------
// tb_switch_debounce
//
// Directed test of switch_debounce with STABLE_COUNT=4. Inputs are driven
// 1 ns after a rising edge and outputs are sampled at the same point, so a
// value driven after edge n-1 is captured by sync1 at edge n. With
// STABLE_COUNT=4 the output then updates at edge n+5.
// ---------------------------------------------------------------------------
module tb_switch_debounce;

  localparam int STABLE_COUNT = 4;
  localparam int CNT_WIDTH    = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [8:1] raw;
  logic [8:1] dout;
  logic [8:1] changed;
  logic       evt;
  logic       ack;

  int         err_cnt = 0;
  int         chk_cnt = 0;
  logic [8:1] chg_acc;

  always #5 clk = ~clk;

  switch_debounce #(
    .STABLE_COUNT(STABLE_COUNT),
    .CNT_WIDTH   (CNT_WIDTH)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .switch_debounce_raw    (raw),
    .switch_debounce_out    (dout),
    .switch_debounce_changed(changed),
    .switch_debounce_event  (evt),
    .switch_debounce_ack    (ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance n rising edges; sample 1 ns after each and accumulate any
  // changed pulse seen along the way.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      chg_acc |= changed;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    raw     = 8'h00;
    ack     = 1'b0;
    chg_acc = 8'h00;

    // ---- Reset values (raw held at 00 during reset) ----
    tick(3);
    check("reset_out", 32'(dout), 32'hFF);
    check("reset_changed", 32'(changed), 32'h00);
    check("reset_event", 32'(evt), 32'h0);

    // ---- First update after release: captured at E1, updates at E6 ----
    reset_n = 1'b1;
    chg_acc = 8'h00;
    tick(5);
    check("rel_out_before", 32'(dout), 32'hFF);
    check("rel_no_early_pulse", 32'(chg_acc), 32'h00);
    tick(1);
    check("rel_out_after", 32'(dout), 32'h00);
    check("rel_changed", 32'(changed), 32'hFF);
    check("rel_event", 32'(evt), 32'h1);
    tick(1);
    check("rel_changed_one_cycle", 32'(changed), 32'h00);
    check("rel_event_sticky", 32'(evt), 32'h1);

    // Lone ack clears; ack while clear does nothing.
    ack = 1'b1;
    tick(1);
    check("ack_clear", 32'(evt), 32'h0);
    tick(1);
    check("ack_when_clear", 32'(evt), 32'h0);
    ack = 1'b0;

    // Return all switches to open, then clear the resulting event.
    raw = 8'hFF;
    tick(6);
    check("open_out", 32'(dout), 32'hFF);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("open_ack", 32'(evt), 32'h0);

    // ---- Bounce rejection: raw[3] low for 3 cycles, 5 times ----
    chg_acc = 8'h00;
    for (int i = 0; i < 5; i++) begin
      raw = 8'hFB;
      tick(3);
      raw = 8'hFF;
      tick(3);
    end
    tick(3);
    check("bounce_out", 32'(dout), 32'hFF);
    check("bounce_changed", 32'(chg_acc), 32'h00);
    check("bounce_event", 32'(evt), 32'h0);

    // ---- Independent bits: raw[1] captured at A, raw[8] at A+2 ----
    raw = 8'hFE;
    tick(2);
    raw = 8'h7E;
    tick(3);
    check("indep_out_A4", 32'(dout), 32'hFF);
    tick(1);
    check("indep_out_A5", 32'(dout), 32'hFE);
    check("indep_changed_A5", 32'(changed), 32'h01);
    check("indep_event_A5", 32'(evt), 32'h1);
    tick(1);
    check("indep_changed_A6", 32'(changed), 32'h00);
    tick(1);
    check("indep_out_A7", 32'(dout), 32'h7E);
    check("indep_changed_A7", 32'(changed), 32'h80);

    // ---- Ack/update collision with event already set ----
    raw = 8'h7F;
    tick(5);
    ack = 1'b1;
    tick(1);
    check("coll_out", 32'(dout), 32'h7F);
    check("coll_changed", 32'(changed), 32'h01);
    check("coll_event_kept", 32'(evt), 32'h1);
    tick(1);
    check("coll_lone_ack", 32'(evt), 32'h0);
    ack = 1'b0;

    // ---- Collision from a clear flag: update must still set it ----
    raw = 8'hFF;
    tick(5);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("coll0_out", 32'(dout), 32'hFF);
    check("coll0_event_set", 32'(evt), 32'h1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("coll0_ack", 32'(evt), 32'h0);

    // ---- Reset mid-count: raw[5] captured at C, reset at C+3 ----
    raw = 8'hEF;
    tick(3);
    reset_n = 1'b0;
    chg_acc = 8'h00;
    tick(1);
    reset_n = 1'b1;
    check("mid_rst_out", 32'(dout), 32'hFF);
    check("mid_rst_changed", 32'(chg_acc), 32'h00);
    check("mid_rst_event", 32'(evt), 32'h0);
    tick(5);
    check("mid_rst_no_early", 32'(dout), 32'hFF);
    tick(1);
    check("mid_rst_out_fresh", 32'(dout), 32'hEF);
    check("mid_rst_changed_fresh", 32'(changed), 32'h10);

    // ---- Restart on agreement: raw[2] 3 low, 1 high, then low ----
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    raw = 8'hED;
    tick(3);
    raw = 8'hEF;
    tick(1);
    raw = 8'hED;
    chg_acc = 8'h00;
    tick(5);
    check("restart_no_early", 32'(dout), 32'hEF);
    check("restart_no_pulse", 32'(chg_acc), 32'h00);
    tick(1);
    check("restart_out", 32'(dout), 32'hED);
    check("restart_changed", 32'(changed), 32'h02);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
# switch_debounce

Synchronises and debounces the eight raw front-panel switch lines and drives the debounced vector into the switch bus-read stage's `switches_input`. The raw pins are active-low (pulled up when open); this block preserves that polarity, and inversion stays in the downstream bus stage. It also reports which bits changed, as a one-cycle pulse and as a sticky event flag that bus logic can poll and acknowledge.

## Interface
- `STABLE_COUNT`, default 50000: consecutive cycles a synchronised bit must differ from its debounced value before the debounced value updates. Legal range is ≥2. At 50 MHz the default is 1 ms.
- `CNT_WIDTH`, default 16: per-bit counter width. Must satisfy 2^CNT_WIDTH > STABLE_COUNT−1.
- `clk` in 1: single system clock. All state changes on its rising edge.
- `reset_n` in 1: reset, synchronous, active-low. Sampled on the rising edge of `clk`.
- `switch_debounce_raw` in [8:1]: asynchronous raw switch pins, active-low.
- `switch_debounce_out` out [8:1]: debounced switch vector, same polarity as raw. Feeds `switches_input`.
- `switch_debounce_changed` out [8:1]: per-bit one-cycle pulse marking that the bit updated on the previous edge.
- `switch_debounce_event` out 1: sticky flag, set when any bit updates.
- `switch_debounce_ack` in 1: synchronous clear for `switch_debounce_event`.

## Operation
- Reset (`reset_n`=0 at a rising edge):
  - both synchroniser stages ← 8'hFF
  - `switch_debounce_out` ← 8'hFF (all switches open)
  - all counters ← 0
  - `switch_debounce_changed` ← 8'h00
  - `switch_debounce_event` ← 0
- Reset asserted mid-count discards all partial counts. There are no glitches on outputs other than the reset values.
- Synchroniser: two flops per bit, `sync1` ← raw, then `sync2` ← `sync1`. Only `sync2` is used downstream.
- Per-bit filter (8 independent identical channels, bit i):
  - If `sync2[i]` == `out[i]`: `cnt[i]` ← 0.
  - If they differ and `cnt[i]` < STABLE_COUNT−1: `cnt[i]` ← `cnt[i]`+1.
  - If they differ and `cnt[i]` == STABLE_COUNT−1: `out[i]` ← `sync2[i]`, `cnt[i]` ← 0, `changed[i]` ← 1.
  - Any single cycle of agreement restarts the count, so a bounce shorter than STABLE_COUNT cycles never reaches the output.
  - The counter never exceeds STABLE_COUNT−1 and never wraps.
- `switch_debounce_changed[i]` is a registered signal, high for exactly the one cycle in which the new `out[i]` is first visible, and 0 otherwise. Several bits may pulse in the same cycle.
- Event flag priority per edge:
  - Reset clears the flag.
  - Else if any bit updates this edge, the flag is set.
  - Else if `switch_debounce_ack`=1, the flag is cleared.
  - Else the flag holds.
  - An update on the same edge as ack wins, so no event is lost.
- Ack while the flag is 0 has no effect.

## Timing
- Raw bit changes and is captured by `sync1` at edge k. `sync2` reflects it after edge k+1. The counter increments on edges k+2 … k+STABLE_COUNT. `out` updates at edge k+1+STABLE_COUNT.
  - Total latency is STABLE_COUNT+2 edges, counting edge k as the first.
  - With STABLE_COUNT=4, the output changes 6 edges after capture.
- `switch_debounce_changed` and `switch_debounce_event` assert on the same edge as the `out` update. The event flag rises with the first `changed` pulse.
- Outputs are purely registered, with no combinational path from any input to any output.
- A raw pulse held for fewer than STABLE_COUNT cycles at `sync2` is fully rejected, and the counter returns to 0 on the first agreeing edge.
- Setup of raw pins relative to `clk` is not required (asynchronous). Metastability is resolved by the 2-flop synchroniser.

## Test plan
All scenarios use STABLE_COUNT=4.
- **Reset values:** hold `reset_n`=0 for 3 edges with raw=8'h00 → `out`=8'hFF, `changed`=8'h00, `event`=0. After release, raw=8'h00 steady → `out`=8'h00 exactly 6 edges later, `changed`=8'hFF for one cycle, `event`=1.
- **Bounce rejection:** raw[3] toggles 1→0→1 with 3-cycle low pulses, repeated 5 times → `out` stays 8'hFF, `changed` never asserts, `event` stays 0.
- **Independent bits:** raw[1] falls at edge 10, raw[8] falls at edge 12 → `out[1]`=0 at edge 15 with `changed`=8'h01, then `out[8]`=0 at edge 17 with `changed`=8'h80.
- **Ack/update collision:** `event`=1, then assert ack on the same edge a new bit update occurs → `event` stays 1. A lone ack on the next cycle → `event`=0. Ack while `event`=0 → no change.
- **Reset mid-count:** raw[5] falls, and `reset_n`=0 is pulsed 3 edges later → after release, `out[5]` updates only after a fresh 6-edge latency. No `changed` pulse occurs during reset.
- **Restart on agreement:** raw[2] low for 3 cycles, high for 1, then low steady → the update occurs 6 edges after the final fall, not earlier.
